sdram_aref_ctrl: RTL and testbench
==================================

SDRAM_AREF_CTRL -- requirements
Module: sdram_aref_ctrl

Interface
REQ-001 SHALL take parameters: T_REFI 2000, refresh interval in sdram_clk cycles (15 us); T_RP 3, precharge-to-AREF cycles; T_RFC 9, AREF-to-next-command cycles; MAX_PEND 8, max postponed refreshes; URGENT_TH 6, debt level that raises urgency; ADDR_BITS 12, address width.
REQ-002 SHALL use clock sdram_clk, rising edge; reset rst_n, asynchronous, active-low.
REQ-003 sdram_clk  in  1  clock.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 init_done  in  1  SDRAM initialisation complete; refresh timing runs only while high.
REQ-006 aref_en  in  1  one-cycle grant pulse from arbiter.
REQ-007 aref_req  out  1  refresh debt nonzero.
REQ-008 aref_urgent  out  1  debt >= URGENT_TH.
REQ-009 aref_busy  out  1  sequence in progress, from the PRE cycle through the aref_done cycle.
REQ-010 aref_done  out  1  one-cycle pulse at sequence end.
REQ-011 aref_ovf  out  1  sticky: a tick arrived with debt at MAX_PEND.
REQ-012 aref_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}; NOP 0111, PRE 0010, AREF 0001.
REQ-013 sdram_addr  out  ADDR_BITS  A10=1 during PRE (all banks), else 0.

Function
REQ-014 SHALL hold an interval counter of width clog2(T_REFI+1), cleared while init_done=0, wrapping to 0 with a one-cycle tick when it reaches T_REFI-1; first tick T_REFI cycles after init_done rises.
REQ-015 SHALL hold a debt counter (0..MAX_PEND): +1 on tick, -1 on each issued AREF, unchanged when both occur in one cycle, saturating at MAX_PEND (tick at saturation sets aref_ovf).
REQ-016 SHALL implement FSM IDLE -> PRE -> WAIT_RP -> AREF -> WAIT_RFC -> (AREF | DONE) -> IDLE.
REQ-017 IDLE: aref_en accepted only when aref_req=1; aref_en while busy or debt=0 SHALL be ignored.
REQ-018 PRE SHALL be issued the cycle after the grant; AREF exactly T_RP cycles after PRE; every other cycle NOP.
REQ-019 After WAIT_RFC (T_RFC cycles after an AREF), SHALL go to AREF again if burst continuation applies (REQ-025), else DONE.
REQ-020 DONE: aref_done=1 for one cycle, T_RFC cycles after the last AREF; next cycle IDLE.
REQ-021 aref_req/aref_urgent SHALL be combinational from debt; debt decrement takes effect the cycle after AREF.
REQ-022 init_done falling mid-sequence SHALL NOT abort the FSM; only the interval counter clears, debt retained.

Reset
REQ-023 On rst_n low: FSM IDLE, counters 0, aref_ovf 0, aref_cmd NOP, sdram_addr 0, aref_req/urgent/busy/done 0; applies immediately, including mid-sequence.

Configuration
REQ-024 Macro SDRAM_AREF_POSTPONE_EN selects postponed-refresh support.
REQ-025 Defined: debt range 0..MAX_PEND; one grant issues back-to-back AREFs (one PRE) until debt reaches 0 (counting ticks arriving during the sequence).
REQ-026 Undefined: debt is 1 bit (0..1); exactly one AREF per grant; aref_urgent ties to aref_req; tick while debt=1 sets aref_ovf; MAX_PEND/URGENT_TH unused.

Structure
REQ-027 Package sdram_pkg SHALL hold command encodings (NOP/PRE/AREF), ADDR_BITS, and the FSM state typedef.
REQ-028 Interval counter plus debt logic SHALL be sub-module sdram_aref_timer; FSM and command decode stay in sdram_aref_ctrl.

Verification
REQ-029 Reset release, init_done=1 at cycle 0 -> tick and aref_req=1 at cycle 2000; no earlier tick.
REQ-030 Debt 1, aref_en at cycle G -> PRE at G+1, AREF at G+4, aref_done at G+13, aref_busy G+1..G+13, aref_req=0 from G+5.
REQ-031 (POSTPONE_EN) debt 3, grant at G -> one PRE at G+1, AREFs at G+4, G+13, G+22, done at G+31, debt 0.
REQ-032 No grants for 9 intervals -> debt saturates at 8, aref_urgent=1 from debt 6, aref_ovf=1 at 9th tick and stays set.
REQ-033 Tick coincides with AREF issue, debt 2 -> debt stays 2; (POSTPONE_EN) burst continues.
REQ-034 rst_n low at G+5 of a sequence -> aref_cmd NOP, busy 0, no aref_done; after release, first tick T_REFI cycles after init_done.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM auto-refresh encodings, state type and build option (SDRAM_AREF_POSTPONE_EN)
package sdram_pkg;

    localparam int ADDR_BITS = 12;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

`ifdef SDRAM_AREF_POSTPONE_EN
    localparam bit POSTPONE_EN = 1'b1;
`else
    localparam bit POSTPONE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_RP,
        ST_AREF,
        ST_WAIT_RFC,
        ST_DONE
    } aref_state_t;

endpackage

// File: rtl/sdram_aref_timer.sv
// rtl/sdram_aref_timer.sv - refresh interval counter and refresh debt tracking (depth set by SDRAM_AREF_POSTPONE_EN)
module sdram_aref_timer
    import sdram_pkg::*;
#(
    parameter int T_REFI    = 2000,
    parameter int MAX_PEND  = 8,
    parameter int URGENT_TH = 6
) (
    input  logic sdram_clk,
    input  logic rst_n,
    input  logic init_done,
    input  logic aref_issue,
    output logic tick,
    output logic aref_req,
    output logic aref_urgent,
    output logic aref_ovf
);

    localparam int CNT_W    = $clog2(T_REFI + 1);
    localparam int DEBT_W   = POSTPONE_EN ? $clog2(MAX_PEND + 1) : 1;
    localparam int DEBT_MAX = POSTPONE_EN ? MAX_PEND : 1;
    localparam int URG_LVL  = POSTPONE_EN ? URGENT_TH : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(T_REFI - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX_V = DEBT_W'(DEBT_MAX);
    localparam logic [DEBT_W-1:0] URG_V      = DEBT_W'(URG_LVL);

    logic              init_q;
    logic [CNT_W-1:0]  cnt;
    logic [DEBT_W-1:0] debt;

    // init_q delays the start so the first tick lands T_REFI cycles after init_done rises
    assign tick = init_q && init_done && (cnt == CNT_LAST);

    // Interval counter: held at zero until initialisation is done, wraps on tick
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            cnt    <= '0;
        end else begin
            init_q <= init_done;
            if (!init_done || !init_q || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Debt: tick adds, issued AREF removes, both together cancel; overflow is sticky
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            debt     <= '0;
            aref_ovf <= 1'b0;
        end else if (tick && !aref_issue) begin
            if (debt == DEBT_MAX_V) begin
                aref_ovf <= 1'b1;
            end else begin
                debt <= debt + DEBT_W'(1);
            end
        end else if (!tick && aref_issue && (debt != '0)) begin
            debt <= debt - DEBT_W'(1);
        end
    end

    assign aref_req    = (debt != '0);
    assign aref_urgent = (debt >= URG_V);

endmodule

// File: rtl/sdram_aref_ctrl.sv
// rtl/sdram_aref_ctrl.sv - SDRAM auto-refresh sequencer: PRE-all then AREF burst (burst when SDRAM_AREF_POSTPONE_EN)
module sdram_aref_ctrl
    import sdram_pkg::*;
#(
    parameter int T_REFI    = 2000,
    parameter int T_RP      = 3,
    parameter int T_RFC     = 9,
    parameter int MAX_PEND  = 8,
    parameter int URGENT_TH = 6,
    parameter int ADDR_BITS = sdram_pkg::ADDR_BITS
) (
    input  logic                 sdram_clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic                 aref_en,
    output logic                 aref_req,
    output logic                 aref_urgent,
    output logic                 aref_busy,
    output logic                 aref_done,
    output logic                 aref_ovf,
    output logic [3:0]           aref_cmd,
    output logic [ADDR_BITS-1:0] sdram_addr
);

    localparam int WAIT_MAX = (T_RFC > T_RP) ? T_RFC : T_RP;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int A10      = 10;

    localparam logic [WAIT_W-1:0] RP_LAST  = WAIT_W'(T_RP - 2);
    localparam logic [WAIT_W-1:0] RFC_LAST = WAIT_W'(T_RFC - 2);

    aref_state_t       state;
    aref_state_t       state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              aref_issue;
    logic              tick;
    logic              burst_more;

    sdram_aref_timer #(
        .T_REFI    (T_REFI),
        .MAX_PEND  (MAX_PEND),
        .URGENT_TH (URGENT_TH)
    ) u_timer (
        .sdram_clk   (sdram_clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .aref_issue  (aref_issue),
        .tick        (tick),
        .aref_req    (aref_req),
        .aref_urgent (aref_urgent),
        .aref_ovf    (aref_ovf)
    );

    // A tick landing in the last tRFC cycle still counts toward the burst
    assign burst_more = POSTPONE_EN && (aref_req || tick);

    // State register
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cycles spent in the current wait state; restarts on every state change
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state != state_nxt) || (state == ST_IDLE)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Next-state: grants only honoured in IDLE with debt outstanding
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (aref_en && aref_req) state_nxt = ST_PRE;
            ST_PRE:      state_nxt = ST_WAIT_RP;
            ST_WAIT_RP:  if (wait_cnt == RP_LAST) state_nxt = ST_AREF;
            ST_AREF:     state_nxt = ST_WAIT_RFC;
            ST_WAIT_RFC: if (wait_cnt == RFC_LAST) state_nxt = burst_more ? ST_AREF : ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Command decode and status outputs
    always_comb begin
        aref_cmd   = CMD_NOP;
        sdram_addr = '0;
        aref_issue = 1'b0;
        aref_busy  = (state != ST_IDLE);
        aref_done  = (state == ST_DONE);
        if (state == ST_PRE) begin
            aref_cmd        = CMD_PRE;
            sdram_addr[A10] = 1'b1;
        end else if (state == ST_AREF) begin
            aref_cmd   = CMD_AREF;
            aref_issue = 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// tb/tb_sdram_aref_ctrl.sv - scoreboard bench for sdram_aref_ctrl
module tb_sdram_aref_ctrl;

    localparam int T_REFI = 2000;
    localparam int T_RP   = 3;
    localparam int T_RFC  = 9;
`ifdef SDRAM_AREF_POSTPONE_EN
    localparam bit PP   = 1'b1;
    localparam int MAXD = 8;
    localparam int URG  = 6;
`else
    localparam bit PP   = 1'b0;
    localparam int MAXD = 1;
    localparam int URG  = 1;
`endif
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;

    logic        sdram_clk;
    logic        rst_n;
    logic        init_done;
    logic        aref_en;
    logic        aref_req;
    logic        aref_urgent;
    logic        aref_busy;
    logic        aref_done;
    logic        aref_ovf;
    logic [3:0]  aref_cmd;
    logic [11:0] sdram_addr;

    sdram_aref_ctrl #(
        .T_REFI    (T_REFI),
        .T_RP      (T_RP),
        .T_RFC     (T_RFC),
        .MAX_PEND  (8),
        .URGENT_TH (6),
        .ADDR_BITS (12)
    ) dut (
        .sdram_clk   (sdram_clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .aref_en     (aref_en),
        .aref_req    (aref_req),
        .aref_urgent (aref_urgent),
        .aref_busy   (aref_busy),
        .aref_done   (aref_done),
        .aref_ovf    (aref_ovf),
        .aref_cmd    (aref_cmd),
        .sdram_addr  (sdram_addr)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic        done;
        logic [11:0] addr;
    } evt_t;

    evt_t exp_q[$];
    evt_t mon_e;
    int   n_chk;
    int   n_fail;
    int   cyc;
    int   t_ref;

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    initial cyc = 0;
    always @(posedge sdram_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_evt(input int c, input logic [3:0] cmd, input logic d, input logic [11:0] a);
        evt_t e;
        e.cyc  = c;
        e.cmd  = cmd;
        e.done = d;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    // Grant driven in cycle g: PRE g+1, AREFs every tRFC from g+4, done tRFC after the last
    task automatic push_seq(input int g, input int n_aref, input bit with_done);
        push_evt(g + 1, PRE, 1'b0, 12'h400);
        for (int i = 0; i < n_aref; i++) push_evt(g + 1 + T_RP + T_RFC * i, AREF, 1'b0, 12'h000);
        if (with_done) push_evt(g + 1 + T_RP + T_RFC * n_aref, NOP, 1'b1, 12'h000);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge sdram_clk);
    endtask

    task automatic grant_pulse(input int hold);
        aref_en = 1'b1;
        repeat (hold) @(negedge sdram_clk);
        aref_en = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int ref_cyc);
        while (!aref_req && (cyc < ref_cyc + T_REFI + 100)) @(negedge sdram_clk);
        chk(tag, cyc - ref_cyc, T_REFI);
    endtask

    function automatic int next_vis();
        return t_ref + ((cyc - t_ref) / T_REFI + 1) * T_REFI;
    endfunction

    // Output monitor: every non-NOP command or done pulse must match the head of the scoreboard
    always @(negedge sdram_clk) begin
        if (rst_n === 1'b1 && (aref_cmd != NOP || aref_done)) begin
            if (exp_q.size() == 0) begin
                chk("evt_unexpected", {27'd0, aref_cmd, aref_done}, {27'd0, NOP, 1'b0});
            end else begin
                mon_e = exp_q.pop_front();
                chk("evt_cyc", cyc, mon_e.cyc);
                chk("evt_cmd", {28'd0, aref_cmd}, {28'd0, mon_e.cmd});
                chk("evt_done", {31'd0, aref_done}, {31'd0, mon_e.done});
                chk("evt_addr", {20'd0, sdram_addr}, {20'd0, mon_e.addr});
            end
        end
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        int n;
        int d_m;
        bit ovf_m;
        bit busy_seen;
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        init_done = 1'b0;
        aref_en = 1'b0;
        t_ref = 0;
        repeat (3) @(negedge sdram_clk);
        chk("rst_cmd", {28'd0, aref_cmd}, {28'd0, NOP});
        chk("rst_addr", {20'd0, sdram_addr}, 0);
        chk("rst_req", {31'd0, aref_req}, 0);
        chk("rst_urgent", {31'd0, aref_urgent}, 0);
        chk("rst_busy", {31'd0, aref_busy}, 0);
        chk("rst_done", {31'd0, aref_done}, 0);
        chk("rst_ovf", {31'd0, aref_ovf}, 0);

        // First tick T_REFI cycles after init_done
        rst_n = 1'b1;
        @(negedge sdram_clk);
        init_done = 1'b1;
        t_ref = cyc + 1;
        wait_req("first_tick", t_ref);

        // Single refresh with debt 1
        g = cyc;
        chk("b_busy_before", {31'd0, aref_busy}, 0);
        push_seq(g, 1, 1'b1);
        grant_pulse(1);
        chk("b_busy_start", {31'd0, aref_busy}, 1);
        wait_until(g + 4);
        chk("b_req_at_aref", {31'd0, aref_req}, 1);
        wait_until(g + 5);
        chk("b_req_cleared", {31'd0, aref_req}, 0);
        wait_until(g + 13);
        chk("b_busy_last", {31'd0, aref_busy}, 1);
        wait_until(g + 14);
        chk("b_busy_idle", {31'd0, aref_busy}, 0);

        // Grant with no debt is ignored
        grant_pulse(1);
        busy_seen = 1'b0;
        repeat (15) begin
            @(negedge sdram_clk);
            busy_seen = busy_seen | aref_busy;
        end
        chk("c_grant_no_debt", {31'd0, busy_seen}, 0);

        // Grant held across busy cycles yields one sequence
        wait_until(t_ref + 2 * T_REFI);
        chk("d_req", {31'd0, aref_req}, 1);
        g = cyc;
        push_seq(g, 1, 1'b1);
        grant_pulse(3);
        wait_until(g + 16);
        chk("d_busy_idle", {31'd0, aref_busy}, 0);
        chk("d_req_idle", {31'd0, aref_req}, 0);

        // init_done drop mid-sequence: sequence completes, interval restarts
        wait_until(t_ref + 3 * T_REFI);
        g = cyc;
        push_seq(g, 1, 1'b1);
        grant_pulse(1);
        wait_until(g + 3);
        init_done = 1'b0;
        wait_until(g + 8);
        init_done = 1'b1;
        t_ref = cyc + 1;
        wait_until(g + 10);
        chk("f_busy_mid", {31'd0, aref_busy}, 1);
        wait_until(g + 14);
        chk("f_req_idle", {31'd0, aref_req}, 0);
        wait_req("f_tick_restart", t_ref);

        // Tick coincides with AREF issue
        if (PP) begin
            wait_until(t_ref + 2 * T_REFI);
            chk("e_req", {31'd0, aref_req}, 1);
        end
        n = PP ? 3 : 1;
        g = next_vis() - 1 - T_RP - 1;
        wait_until(g);
        push_seq(g, n, 1'b1);
        grant_pulse(1);
        wait_until(g + 5);
        chk("e_req_after_aref", {31'd0, aref_req}, 1);
        wait_until(g + 1 + T_RP + T_RFC * n + 1);
        chk("e_req_end", {31'd0, aref_req}, PP ? 0 : 1);
        chk("e_ovf", {31'd0, aref_ovf}, 0);

        // Nine intervals without grants: saturation, urgency, overflow
        d_m = PP ? 0 : 1;
        ovf_m = 1'b0;
        for (int k = 0; k < 9; k++) begin
            wait_until(next_vis());
            if (d_m == MAXD) ovf_m = 1'b1;
            else d_m++;
            chk("sat_req", {31'd0, aref_req}, (d_m != 0) ? 1 : 0);
            chk("sat_urgent", {31'd0, aref_urgent}, (d_m >= URG) ? 1 : 0);
            chk("sat_ovf", {31'd0, aref_ovf}, {31'd0, ovf_m});
        end
        repeat (5) @(negedge sdram_clk);
        chk("ovf_sticky", {31'd0, aref_ovf}, 1);

        // Reset in the middle of a sequence
        g = cyc;
        push_seq(g, 1, 1'b0);
        grant_pulse(1);
        wait_until(g + 5);
        rst_n = 1'b0;
        #1;
        chk("h_cmd", {28'd0, aref_cmd}, {28'd0, NOP});
        chk("h_busy", {31'd0, aref_busy}, 0);
        chk("h_done", {31'd0, aref_done}, 0);
        chk("h_ovf", {31'd0, aref_ovf}, 0);
        chk("h_req", {31'd0, aref_req}, 0);
        chk("h_addr", {20'd0, sdram_addr}, 0);
        repeat (4) @(negedge sdram_clk);
        rst_n = 1'b1;
        t_ref = cyc + 1;
        wait_req("h_tick_after_rst", t_ref);

        repeat (3) @(negedge sdram_clk);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
